// File: rtl/debouncer_bank.sv
// -----------------------------------------------------------------------------
// debouncer_bank
//   Bank of independent push-button debouncers. Each channel synchronises its
//   raw input through two flops. The channel then commits a new debounced level
//   only after the synchronised input has disagreed with the current level for
//   COUNT_VALUE consecutive cycles. A commit to 1 or to 0 produces a one-cycle
//   press or release pulse. Once the debounced level has been 1 for HOLD_VALUE
//   cycles, a single one-cycle hold pulse is produced.
//
// Parameters
//   CHANNELS      : number of independent channels (>= 1)
//   CLK_FREQUENCY : clock frequency in Hz
//   DEBOUNCE_HZ   : COUNT_VALUE = CLK_FREQUENCY / DEBOUNCE_HZ (>= 2)
//   HOLD_HZ       : HOLD_VALUE  = CLK_FREQUENCY / HOLD_HZ     (>= 2)
//
// Ports
//   clk           : single clock, rising edge
//   reset         : synchronous, active-high
//   button        : raw asynchronous inputs, one bit per channel
//   stable        : registered debounced level per channel
//   press         : one-cycle pulse on each debounced 0->1 commit
//   release_pulse : one-cycle pulse on each debounced 1->0 commit
//                   (this is the "release" output; `release` is a reserved word)
//   hold          : one-cycle pulse once the level has been 1 for HOLD_VALUE cycles
// -----------------------------------------------------------------------------
module debouncer_bank #(
  parameter int CHANNELS      = 4,
  parameter int CLK_FREQUENCY = 40_000_000,
  parameter int DEBOUNCE_HZ   = 2,
  parameter int HOLD_HZ       = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] hold
);

  localparam int COUNT_VALUE = CLK_FREQUENCY / DEBOUNCE_HZ;
  localparam int HOLD_VALUE  = CLK_FREQUENCY / HOLD_HZ;
  localparam int CW          = $clog2(COUNT_VALUE);
  localparam int HW          = $clog2(HOLD_VALUE);

  localparam logic [CW-1:0] CNT_MAX  = CW'(COUNT_VALUE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_VALUE - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};

  logic [CHANNELS-1:0]         sync1_q,     sync1_d;
  logic [CHANNELS-1:0]         sync2_q,     sync2_d;
  logic [CHANNELS-1:0]         stable_q,    stable_d;
  logic [CHANNELS-1:0]         press_q,     press_d;
  logic [CHANNELS-1:0]         release_q,   release_d;
  logic [CHANNELS-1:0]         hold_q,      hold_d;
  // Set once the hold pulse has fired for the current press; blocks auto-repeat.
  logic [CHANNELS-1:0]         hold_done_q, hold_done_d;
  logic [CHANNELS-1:0][CW-1:0] cnt_q,       cnt_d;
  logic [CHANNELS-1:0][HW-1:0] hold_cnt_q,  hold_cnt_d;
  logic [CHANNELS-1:0]         commit_s;

  // Next-state logic for the synchronisers, debounce counters and hold tracking.
  always_comb begin
    sync1_d     = button;
    sync2_d     = sync1_q;
    stable_d    = stable_q;
    press_d     = {CHANNELS{1'b0}};
    release_d   = {CHANNELS{1'b0}};
    hold_d      = {CHANNELS{1'b0}};
    hold_done_d = hold_done_q;
    cnt_d       = cnt_q;
    hold_cnt_d  = hold_cnt_q;
    commit_s    = {CHANNELS{1'b0}};

    for (int ch = 0; ch < CHANNELS; ch++) begin
      // Debounce: any agreement with the current level throws the count away.
      if (sync2_q[ch] == stable_q[ch]) begin
        cnt_d[ch] = CNT_ZERO;
      end else if (cnt_q[ch] == CNT_MAX) begin
        commit_s[ch]  = 1'b1;
        stable_d[ch]  = sync2_q[ch];
        cnt_d[ch]     = CNT_ZERO;
        press_d[ch]   = sync2_q[ch];
        release_d[ch] = ~sync2_q[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
      end

      // The hold pulse fires on the cycle after the counter saturates, exactly once.
      hold_d[ch] = stable_q[ch] & (hold_cnt_q[ch] == HOLD_MAX) & ~hold_done_q[ch];

      // A commit in either direction restarts hold tracking. Any commit while the
      // level is 1 is a release; a commit while it is 0 (a press) starts from zero.
      if (!stable_q[ch] || commit_s[ch]) begin
        hold_cnt_d[ch]  = HOLD_ZERO;
        hold_done_d[ch] = 1'b0;
      end else begin
        if (hold_cnt_q[ch] != HOLD_MAX) begin
          hold_cnt_d[ch] = hold_cnt_q[ch] + HOLD_ONE;
        end else begin
          hold_cnt_d[ch] = hold_cnt_q[ch];
        end
        hold_done_d[ch] = hold_done_q[ch] | hold_d[ch];
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= {CHANNELS{1'b0}};
      sync2_q     <= {CHANNELS{1'b0}};
      stable_q    <= {CHANNELS{1'b0}};
      press_q     <= {CHANNELS{1'b0}};
      release_q   <= {CHANNELS{1'b0}};
      hold_q      <= {CHANNELS{1'b0}};
      hold_done_q <= {CHANNELS{1'b0}};
      cnt_q       <= {(CHANNELS*CW){1'b0}};
      hold_cnt_q  <= {(CHANNELS*HW){1'b0}};
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      press_q     <= press_d;
      release_q   <= release_d;
      hold_q      <= hold_d;
      hold_done_q <= hold_done_d;
      cnt_q       <= cnt_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign stable        = stable_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign hold          = hold_q;

endmodule

// File: tb/tb_debouncer_bank.sv
// -----------------------------------------------------------------------------
// tb_debouncer_bank
//   Drives directed and random button patterns into a 2-channel debouncer bank.
//   For every clock edge, a reference model predicts the outputs and queues them.
//   A separate monitor pops one prediction per edge and compares it against the DUT.
//   The model works from the behavioural rules, not from counter registers:
//   - the synchroniser is a two-deep sample delay;
//   - a level commits when the last COUNT_VALUE synchronised samples all
//     disagree with it;
//   - hold fires exactly HOLD_VALUE edges after the rise.
// -----------------------------------------------------------------------------
module tb_debouncer_bank;

  localparam int CH = 2;
  localparam int CV = 10;   // 100 / 10
  localparam int HV = 50;   // 100 / 2
  localparam logic [CV-1:0] ALL_ONES  = {CV{1'b1}};
  localparam logic [CV-1:0] ALL_ZEROS = {CV{1'b0}};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] stable, press, release_pulse, hold;

  typedef struct packed {
    logic [CH-1:0] st;
    logic [CH-1:0] pr;
    logic [CH-1:0] rl;
    logic [CH-1:0] hd;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state.
  logic [CH-1:0] m_d1 = '0, m_d2 = '0, m_stable = '0;
  logic [CV-1:0] m_hist [CH];
  int            m_fill [CH];
  int            m_rise [CH];
  int            edge_no = 0;

  debouncer_bank #(
    .CHANNELS(CH), .CLK_FREQUENCY(100), .DEBOUNCE_HZ(10), .HOLD_HZ(2)
  ) dut (
    .clk(clk), .reset(reset), .button(button),
    .stable(stable), .press(press), .release_pulse(release_pulse), .hold(hold)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and push the predicted post-edge outputs.
  task automatic step(input logic rst, input logic [CH-1:0] btn);
    exp_t e;
    logic s2;
    @(negedge clk);
    reset  = rst;
    button = btn;
    edge_no++;
    e = '0;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0;
      for (int c = 0; c < CH; c++) begin
        m_hist[c] = ALL_ZEROS; m_fill[c] = 0; m_rise[c] = -1;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        s2 = m_d2[c];
        m_hist[c] = {m_hist[c][CV-2:0], s2};
        if (m_fill[c] < CV) m_fill[c]++;
        if (m_stable[c] && m_rise[c] >= 0 && (edge_no - m_rise[c]) == HV) e.hd[c] = 1'b1;
        if (m_fill[c] >= CV && m_hist[c] == (m_stable[c] ? ALL_ZEROS : ALL_ONES)) begin
          m_stable[c] = ~m_stable[c];
          if (m_stable[c]) begin
            e.pr[c] = 1'b1; m_rise[c] = edge_no;
          end else begin
            e.rl[c] = 1'b1; m_rise[c] = -1;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = btn;
    end
    e.st = m_stable;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic rst, input logic [CH-1:0] btn);
    for (int i = 0; i < n; i++) step(rst, btn);
  endtask

  // Monitor: one prediction per clock edge, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    int   mon_edge;
    mon_edge = 0;
    wait (exp_q.size() > 0);
    forever begin
      @(posedge clk);
      #1;
      mon_edge++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL scoreboard_underflow edge %0d: no prediction queued", mon_edge);
      end else begin
        e = exp_q.pop_front();
        if ({stable, press, release_pulse, hold} !== e) begin
          mismatched++;
          $display("FAIL outputs edge %0d: got st=%b pr=%b rl=%b hd=%b, expected st=%b pr=%b rl=%b hd=%b",
                   mon_edge, stable, press, release_pulse, hold, e.st, e.pr, e.rl, e.hd);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1);
  end

  // Stimulus: directed scenarios followed by random bouncy traffic.
  initial begin
    logic [CH-1:0] lvl, b;
    int len, gap;
    for (int c = 0; c < CH; c++) begin
      m_hist[c] = ALL_ZEROS; m_fill[c] = 0; m_rise[c] = -1;
    end

    run(3, 1'b1, 2'b00);
    run(5, 1'b0, 2'b00);

    // Clean press on channel 0, held long enough for one hold pulse, then release.
    run(100, 1'b0, 2'b01);
    run(30, 1'b0, 2'b00);

    // Pulse one cycle short of the window, then short glitch bursts.
    run(9, 1'b0, 2'b01);
    run(15, 1'b0, 2'b00);
    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, 5);
      gap = $urandom_range(1, 5);
      run(len, 1'b0, 2'b01);
      run(gap, 1'b0, 2'b00);
    end
    run(15, 1'b0, 2'b00);

    // Channel 1 toggles every 3 cycles while channel 0 does a clean press.
    for (int i = 0; i < 80; i++) step(1'b0, {1'(((i / 3) % 2) != 0), 1'b1});
    run(40, 1'b0, 2'b00);

    // Reset in the middle of a press count, released with the button still high.
    run(8, 1'b0, 2'b01);
    run(2, 1'b1, 2'b01);
    run(20, 1'b0, 2'b01);
    run(20, 1'b0, 2'b00);

    // Random bouncy traffic with occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      lvl = CH'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        run(int'($urandom_range(1, 3)), 1'b1, lvl);
      end else begin
        len = $urandom_range(1, 70);
        for (int i = 0; i < len; i++) begin
          b = lvl;
          if ($urandom_range(0, 15) == 0) b = b ^ CH'($urandom_range(1, 3));
          step(1'b0, b);
        end
      end
    end
    run(20, 1'b0, 2'b00);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_leftover: %0d predictions not consumed, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
